// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder exposing a 2**addr_width x data_width register
// file. The first byte of a frame is a command (MSB = write, low bits = start
// address); every following byte is data with auto-incrementing address.
// Everything runs in the clk domain; sclk/cs_n/mosi are oversampled.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, cs_n, mosi    SPI inputs from the master (asynchronous)
//   miso                SPI data to the master
//   host_addr           on-chip read address
//   host_rdata          register[host_addr], one-cycle latency
//   reg_wr_valid/addr/data  one-cycle strobe per SPI register write
//   busy                frame in progress
//   frame_err           one-cycle pulse when a frame ends mid-byte
module spi_reg_slave #(
  parameter int unsigned clk_frequency = 50_000_000,
  parameter int unsigned spi_frequency = 5_000_000,
  parameter int unsigned data_width    = 8,
  parameter int unsigned addr_width    = 4,
  parameter bit          CPOL          = 1'b0,
  parameter bit          CPHA          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [addr_width-1:0] host_addr,
  output logic [data_width-1:0] host_rdata,
  output logic                  reg_wr_valid,
  output logic [addr_width-1:0] reg_wr_addr,
  output logic [data_width-1:0] reg_wr_data,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned depth = 2 ** addr_width;
  localparam int unsigned cnt_w = (data_width > 1) ? $clog2(data_width) : 1;

  // Elaboration-time sanity checks on the parameter set.
  if (clk_frequency < 8 * spi_frequency) begin : g_bad_clk_ratio
    $error("spi_reg_slave: clk_frequency must be >= 8*spi_frequency");
  end
  if (data_width < addr_width + 1) begin : g_bad_width
    $error("spi_reg_slave: data_width must be >= addr_width+1");
  end

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sclk_sync, cs_sync, mosi_sync;
  logic                  sclk_prev, cs_prev;
  logic [cnt_w-1:0]      bit_cnt;
  logic [data_width-2:0] rx_shift;
  logic [data_width-2:0] tx_shift;
  logic [addr_width-1:0] addr;
  logic                  rw_write;
  logic [data_width-1:0] regs [depth];

  logic sclk_s, cs_s, mosi_s;
  logic lead_c, trail_c, sample_c, shift_c, cs_fall_c, cs_rise_c;
  logic byte_done_c, abort_c;
  logic [data_width-1:0] byte_c;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {2{CPOL}};
      sclk_prev <= CPOL;
      cs_sync   <= '0;
      cs_prev   <= 1'b0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sclk_prev <= sclk_sync[1];
      cs_sync   <= {cs_sync[0], cs_n};
      cs_prev   <= cs_sync[1];
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign lead_c    = (sclk_s != sclk_prev) && (sclk_s != CPOL);
  assign trail_c   = (sclk_s != sclk_prev) && (sclk_s == CPOL);
  assign sample_c  = CPHA ? trail_c : lead_c;
  assign shift_c   = CPHA ? lead_c : trail_c;
  // cs_n sync resets low, so a cs_n already low at release is not a fall.
  assign cs_fall_c = cs_prev & ~cs_s;
  assign cs_rise_c = ~cs_prev & cs_s;
  assign byte_c    = {rx_shift, mosi_s};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and frame control strobes.
  always_comb begin
    state_d     = state_q;
    byte_done_c = 1'b0;
    abort_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_c) state_d = CMD;
      end
      CMD, DATA: begin
        if (cs_rise_c) begin
          state_d = IDLE;
          abort_c = (bit_cnt != '0);
        end else if (sample_c && (bit_cnt == cnt_w'(data_width - 1))) begin
          byte_done_c = 1'b1;
          state_d     = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shifters, register file, host port and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      addr         <= '0;
      rw_write     <= 1'b0;
      miso         <= 1'b0;
      host_rdata   <= '0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      for (int i = 0; i < int'(depth); i++) regs[i] <= '0;
    end else begin
      reg_wr_valid <= 1'b0;
      frame_err    <= abort_c;
      busy         <= (state_d != IDLE);
      host_rdata   <= regs[host_addr];

      if (state_q == IDLE || cs_rise_c) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        if (sample_c) begin
          rx_shift <= byte_c[data_width-2:0];
          bit_cnt  <= byte_done_c ? '0 : bit_cnt + 1'b1;
          if (byte_done_c) begin
            if (state_q == CMD) begin
              rw_write <= byte_c[data_width-1];
              addr     <= byte_c[addr_width-1:0];
            end else begin
              if (rw_write) begin
                regs[addr]   <= byte_c;
                reg_wr_valid <= 1'b1;
                reg_wr_addr  <= addr;
                reg_wr_data  <= byte_c;
              end
              addr <= addr + 1'b1;
            end
          end
        end
        // A shift edge with the counter at zero is the start of a read byte:
        // load the addressed register and present its MSB.
        if (shift_c && state_q == DATA && !rw_write) begin
          if (bit_cnt == '0) begin
            miso     <= regs[addr][data_width-1];
            tx_shift <= regs[addr][data_width-2:0];
          end else begin
            miso     <= tx_shift[data_width-2];
            tx_shift <= tx_shift << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: three instances cover (CPOL,CPHA) = (0,0), (1,1),
// (0,1). Expected writes and received bytes go into queues; monitors compare.
module tb_spi_reg_slave;

  localparam int unsigned half = 8;  // clk cycles per half SPI period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sclk = 3'b010;
  logic [2:0] cs_n = 3'b111;
  logic [2:0] mosi = 3'b000;
  logic [2:0] miso, wr_valid, busy, ferr;
  logic [3:0] host_addr [3];
  logic [7:0] host_rdata [3];
  logic [3:0] wr_addr [3];
  logic [7:0] wr_data [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    spi_reg_slave #(
      .data_width(8),
      .addr_width(4),
      .CPOL(1'(gi == 1)),
      .CPHA(1'(gi != 0))
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .sclk(sclk[gi]),
      .cs_n(cs_n[gi]),
      .mosi(mosi[gi]),
      .miso(miso[gi]),
      .host_addr(host_addr[gi]),
      .host_rdata(host_rdata[gi]),
      .reg_wr_valid(wr_valid[gi]),
      .reg_wr_addr(wr_addr[gi]),
      .reg_wr_data(wr_data[gi]),
      .busy(busy[gi]),
      .frame_err(ferr[gi])
    );
  end

  typedef struct {int mode; logic [7:0] data;} rx_t;
  typedef struct {int mode; logic [3:0] addr; logic [7:0] data;} wr_t;

  rx_t exp_rx[$];
  rx_t got_rx[$];
  wr_t exp_wr[$];
  int  checks = 0;
  int  failures = 0;
  int  ferr_cnt [3] = '{0, 0, 0};

  task automatic check(input string name, input int mode,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s mode=%0d actual=0x%0h required=0x%0h", name, mode, act, exp);
    end
  endtask

  task automatic wait_half(input int n);
    repeat (n * int'(half)) @(negedge clk);
  endtask

  // Write-strobe, frame-error and received-byte monitors.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ferr[g]) ferr_cnt[g]++;
      if (wr_valid[g]) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", g, 32'(wr_valid[g]), 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_mode", g, 32'(g), 32'(e.mode));
          check("wr_addr", g, 32'(wr_addr[g]), 32'(e.addr));
          check("wr_data", g, 32'(wr_data[g]), 32'(e.data));
        end
      end
    end
    while (got_rx.size() > 0) begin
      rx_t r;
      r = got_rx.pop_front();
      if (exp_rx.size() == 0) begin
        check("rx_unexpected", r.mode, 32'(r.data), 32'hFFFF_FFFF);
      end else begin
        rx_t e;
        e = exp_rx.pop_front();
        check("rx_byte", r.mode, 32'(r.data), 32'(e.data));
      end
    end
  end

  // Master side of one byte (or nbits of it), MSB first.
  task automatic spi_byte(input int g, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic cpol, cpha;
    cpol = (g == 1);
    cpha = (g != 0);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[g] = tx[i];
        wait_half(1);
        sclk[g] = ~cpol;
        rx[i] = miso[g];
        wait_half(1);
        sclk[g] = cpol;
      end else begin
        sclk[g] = ~cpol;
        mosi[g] = tx[i];
        wait_half(1);
        sclk[g] = cpol;
        rx[i] = miso[g];
        wait_half(1);
      end
    end
  endtask

  // Full frame: n bytes from txw (MSB byte first), expected MISO bytes in rxw,
  // expected write addresses of data bytes in wa (nibble per data byte, only
  // used for write commands), optional partial trailing byte of tail bits.
  task automatic spi_frame(input int g, input int n, input logic [31:0] txw,
                           input logic [31:0] rxw, input logic [15:0] wa,
                           input int tail);
    logic [7:0] r;
    cs_n[g] = 1'b0;
    wait_half(2);
    check("busy_on", g, 32'(busy[g]), 32'd1);
    for (int k = 0; k < n; k++) begin
      exp_rx.push_back(rx_t'{mode: g, data: rxw[31-8*k -: 8]});
      if (k > 0 && txw[31])
        exp_wr.push_back(wr_t'{mode: g, addr: wa[19-4*k -: 4], data: txw[31-8*k -: 8]});
      spi_byte(g, txw[31-8*k -: 8], 8, r);
      got_rx.push_back(rx_t'{mode: g, data: r});
    end
    if (tail > 0) spi_byte(g, txw[31-8*n -: 8], tail, r);
    wait_half(1);
    cs_n[g] = 1'b1;
    wait_half(3);
    check("busy_off", g, 32'(busy[g]), 32'd0);
  endtask

  task automatic host_check(input int g, input logic [3:0] a,
                            input logic [7:0] e, input string nm);
    host_addr[g] = a;
    @(negedge clk);
    check(nm, g, 32'(host_rdata[g]), 32'(e));
  endtask

  task automatic out_zero_check(input int g, input string nm);
    check(nm, g, {8'd0, miso[g], busy[g], ferr[g], wr_valid[g], wr_addr[g],
                  wr_data[g], host_rdata[g]}, 32'd0);
  endtask

  task automatic run_mode(input int g);
    int f0;
    logic [7:0] r;
    f0 = ferr_cnt[g];
    // sclk toggling with cs_n high must be ignored
    repeat (4) begin
      sclk[g] = ~sclk[g];
      wait_half(1);
    end
    check("idle_busy", g, 32'(busy[g]), 32'd0);
    // single write, then read back
    spi_frame(g, 2, 32'h83A5_0000, 32'h0, 16'h3000, 0);
    check("wr_drain", g, 32'(exp_wr.size()), 32'd0);
    host_check(g, 4'd3, 8'hA5, "host_reg3");
    spi_frame(g, 2, 32'h0300_0000, 32'h00A5_0000, 16'h0, 0);
    // burst write with wrap, then burst read
    spi_frame(g, 4, 32'h8E11_2233, 32'h0, 16'hEF00, 0);
    check("burst_drain", g, 32'(exp_wr.size()), 32'd0);
    host_check(g, 4'd14, 8'h11, "host_reg14");
    host_check(g, 4'd15, 8'h22, "host_reg15");
    host_check(g, 4'd0, 8'h33, "host_reg0");
    spi_frame(g, 4, 32'h0E00_0000, 32'h0011_2233, 16'h0, 0);
    check("ferr_none", g, 32'(ferr_cnt[g] - f0), 32'd0);
    // aborted byte
    spi_frame(g, 1, 32'h855A_0000, 32'h0, 16'h0, 5);
    check("abort_ferr", g, 32'(ferr_cnt[g] - f0), 32'd1);
    host_check(g, 4'd5, 8'h00, "abort_reg5");
    spi_frame(g, 2, 32'h855A_0000, 32'h0, 16'h5000, 0);
    host_check(g, 4'd5, 8'h5A, "host_reg5");
    spi_frame(g, 2, 32'h0500_0000, 32'h005A_0000, 16'h0, 0);
    check("ferr_once", g, 32'(ferr_cnt[g] - f0), 32'd1);
    // reset in the middle of a write data byte to reg2
    host_addr[g] = 4'd5;
    cs_n[g] = 1'b0;
    wait_half(2);
    exp_rx.push_back(rx_t'{mode: g, data: 8'h00});
    spi_byte(g, 8'h82, 8, r);
    got_rx.push_back(rx_t'{mode: g, data: r});
    spi_byte(g, 8'hFF, 4, r);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    out_zero_check(g, "midrst_outputs");
    rst_n = 1'b1;
    wait_half(2);
    check("midrst_no_start", g, 32'(busy[g]), 32'd0);
    cs_n[g] = 1'b1;
    wait_half(2);
    host_check(g, 4'd2, 8'h00, "midrst_reg2");
    host_check(g, 4'd5, 8'h00, "midrst_reg5");
    spi_frame(g, 2, 32'h0200_0000, 32'h0, 16'h0, 0);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) host_addr[g] = 4'd0;
    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) out_zero_check(g, "reset_outputs");
    rst_n = 1'b1;
    wait_half(2);
    for (int g = 0; g < 3; g++) run_mode(g);
    wait_half(2);
    check("rx_drain", 0, 32'(exp_rx.size()), 32'd0);
    check("wr_final_drain", 0, 32'(exp_wr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
